// File: rtl/cache_pkg.sv
// Shared cache-port types: array enable bundles, status packet and port arbitration enums.
package cache_pkg;

  typedef struct packed {
    logic data;
    logic tag;
    logic status;
  } data_enable_t;

  typedef struct packed {
    logic       valid;
    logic       dirty;
    logic [1:0] lru;
  } status_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_OWN,
    STORE_OWN
  } arb_state_t;

  typedef enum logic {
    LOAD,
    STORE
  } arb_owner_t;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Cache array port bundle: load/store controller request side and the muxed array side.
interface dcache_port_arbiter_if;
  import cache_pkg::*;

  logic           ldu_request_i;
  logic           ldu_release_i;
  logic           ldu_grant_o;
  logic [31:0]    ldu_address_i;
  data_enable_t   ldu_read_i;
  data_enable_t   ldu_write_i;
  logic [31:0]    ldu_data_i;
  status_packet_t ldu_status_i;

  logic           stu_request_i;
  logic           stu_release_i;
  logic           stu_grant_o;
  logic [31:0]    stu_address_i;
  data_enable_t   stu_read_i;
  data_enable_t   stu_write_i;
  logic [31:0]    stu_data_i;
  logic [3:0]     stu_byte_i;
  status_packet_t stu_status_i;

  logic [31:0]    cache_address_o;
  data_enable_t   cache_read_o;
  data_enable_t   cache_write_o;
  logic [31:0]    cache_data_o;
  logic [3:0]     cache_byte_o;
  status_packet_t cache_status_o;

  modport slave (
    input  ldu_request_i, ldu_release_i, ldu_address_i, ldu_read_i, ldu_write_i,
           ldu_data_i, ldu_status_i,
    input  stu_request_i, stu_release_i, stu_address_i, stu_read_i, stu_write_i,
           stu_data_i, stu_byte_i, stu_status_i,
    output ldu_grant_o, stu_grant_o,
    output cache_address_o, cache_read_o, cache_write_o, cache_data_o, cache_byte_o,
           cache_status_o
  );

  modport master (
    output ldu_request_i, ldu_release_i, ldu_address_i, ldu_read_i, ldu_write_i,
           ldu_data_i, ldu_status_i,
    output stu_request_i, stu_release_i, stu_address_i, stu_read_i, stu_write_i,
           stu_data_i, stu_byte_i, stu_status_i,
    input  ldu_grant_o, stu_grant_o,
    input  cache_address_o, cache_read_o, cache_write_o, cache_data_o, cache_byte_o,
           cache_status_o
  );

endinterface

// File: rtl/dcache_port_arbiter.sv
// Transaction-locked load/store arbiter for the single data-cache array port; zero-latency grant from IDLE.
// Round-robin by default; DCACHE_ARB_STARVE_GUARD_EN selects load priority with a store starvation guard.
module dcache_port_arbiter
  import cache_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  input logic                  halt_i,
  dcache_port_arbiter_if.slave bus
);

  arb_state_t r_state, w_state_nxt;
  arb_owner_t r_last, w_last_nxt;
  logic       w_ldu_gnt, w_stu_gnt;
  logic       w_tie_to_stu;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] r_starve_cnt;
  logic       w_unused_last;

  // Load normally wins ties; a store that has waited the full limit takes the port instead.
  assign w_tie_to_stu  = (r_starve_cnt == LP_LIMIT);
  assign w_unused_last = r_last;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve_cnt <= '0;
    end else if (!halt_i) begin
      if (w_stu_gnt) begin
        r_starve_cnt <= '0;
      end else if (bus.stu_request_i && (r_starve_cnt != LP_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end
`else
  logic [7:0] w_unused_limit;

  assign w_unused_limit = 8'(STARVE_LIMIT);
  assign w_tie_to_stu   = (r_last == LOAD);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_last  <= STORE;
    end else if (!halt_i) begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_ldu_gnt   = 1'b0;
    w_stu_gnt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Grant is combinational here, so reset must also mask it while the controllers are held.
        if (!halt_i && rst_n_i) begin
          if (bus.stu_request_i && (!bus.ldu_request_i || w_tie_to_stu)) begin
            w_stu_gnt   = 1'b1;
            w_state_nxt = STORE_OWN;
            w_last_nxt  = STORE;
          end else if (bus.ldu_request_i) begin
            w_ldu_gnt   = 1'b1;
            w_state_nxt = LOAD_OWN;
            w_last_nxt  = LOAD;
          end
        end
      end
      LOAD_OWN: begin
        w_ldu_gnt = 1'b1;
        if (bus.ldu_release_i) begin
          if (bus.stu_request_i) begin
            w_state_nxt = STORE_OWN;
            w_last_nxt  = STORE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      STORE_OWN: begin
        w_stu_gnt = 1'b1;
        if (bus.stu_release_i) begin
          if (bus.ldu_request_i) begin
            w_state_nxt = LOAD_OWN;
            w_last_nxt  = LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ldu_grant_o = w_ldu_gnt;
  assign bus.stu_grant_o = w_stu_gnt;

  always_comb begin
    bus.cache_address_o = w_stu_gnt ? bus.stu_address_i : bus.ldu_address_i;
    bus.cache_read_o    = '0;
    bus.cache_write_o   = '0;
    bus.cache_data_o    = '0;
    bus.cache_byte_o    = '0;
    bus.cache_status_o  = '0;
    if (w_ldu_gnt) begin
      bus.cache_read_o   = bus.ldu_read_i;
      bus.cache_write_o  = bus.ldu_write_i;
      bus.cache_data_o   = bus.ldu_data_i;
      bus.cache_byte_o   = '1;
      bus.cache_status_o = bus.ldu_status_i;
    end else if (w_stu_gnt) begin
      bus.cache_read_o   = bus.stu_read_i;
      bus.cache_write_o  = bus.stu_write_i;
      bus.cache_data_o   = bus.stu_data_i;
      bus.cache_byte_o   = bus.stu_byte_i;
      bus.cache_status_o = bus.stu_status_i;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter (default round-robin build): directed sequence then random traffic.
module tb_dcache_port_arbiter;
  import cache_pkg::*;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic halt_i;

  dcache_port_arbiter_if bus ();

  dcache_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .halt_i  (halt_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic           lg;
    logic           sg;
    logic [31:0]    addr;
    data_enable_t   rd;
    data_enable_t   wr;
    logic [31:0]    dat;
    logic [3:0]     be;
    status_packet_t st;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference: who owns the port (0 none, 1 load, 2 store) and who won most recently.
  int m_own  = 0;
  int m_last = 2;

  task automatic step(input bit lreq, input bit lrel, input bit sreq, input bit srel,
                      input bit hlt, input bit rst);
    obs_t           e;
    int             g;
    int             other;
    bit             other_req;
    logic [31:0]    la, sa, ld, sd;
    data_enable_t   lr, lw, sr, sw;
    status_packet_t ls, ss;
    logic [3:0]     sb;
    la = $urandom; sa = $urandom; ld = $urandom; sd = $urandom;
    lr = data_enable_t'(3'($urandom)); lw = data_enable_t'(3'($urandom));
    sr = data_enable_t'(3'($urandom)); sw = data_enable_t'(3'($urandom));
    ls = status_packet_t'(4'($urandom)); ss = status_packet_t'(4'($urandom));
    sb = 4'($urandom);
    @(negedge clk_i);
    rst_n_i = rst; halt_i = hlt;
    bus.ldu_request_i = lreq; bus.ldu_release_i = lrel;
    bus.stu_request_i = sreq; bus.stu_release_i = srel;
    bus.ldu_address_i = la; bus.ldu_read_i = lr; bus.ldu_write_i = lw;
    bus.ldu_data_i = ld; bus.ldu_status_i = ls;
    bus.stu_address_i = sa; bus.stu_read_i = sr; bus.stu_write_i = sw;
    bus.stu_data_i = sd; bus.stu_byte_i = sb; bus.stu_status_i = ss;

    if (!rst) begin
      m_own  = 0;
      m_last = 2;
    end
    g = m_own;
    if (rst && !hlt && m_own == 0) begin
      if (lreq && sreq) g = (m_last == 1) ? 2 : 1;
      else              g = lreq ? 1 : (sreq ? 2 : 0);
    end

    e.lg   = (g == 1);
    e.sg   = (g == 2);
    e.addr = (g == 2) ? sa : la;
    e.rd   = (g == 1) ? lr : (g == 2) ? sr : data_enable_t'(3'd0);
    e.wr   = (g == 1) ? lw : (g == 2) ? sw : data_enable_t'(3'd0);
    e.dat  = (g == 1) ? ld : (g == 2) ? sd : 32'd0;
    e.be   = (g == 1) ? 4'hF : (g == 2) ? sb : 4'h0;
    e.st   = (g == 1) ? ls : (g == 2) ? ss : status_packet_t'(4'd0);
    exp_q.push_back(e);

    // Advance to the ownership seen after the coming clock edge.
    if (rst && !hlt) begin
      if (m_own == 0) begin
        m_own = g;
        if (g != 0) m_last = g;
      end else if ((m_own == 1 && lrel) || (m_own == 2 && srel)) begin
        other     = 3 - m_own;
        other_req = (other == 1) ? lreq : sreq;
        m_own     = other_req ? other : 0;
        if (other_req) m_last = other;
      end
    end
  endtask

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk_i);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {bus.ldu_grant_o, bus.stu_grant_o, bus.cache_address_o, bus.cache_read_o,
             bus.cache_write_o, bus.cache_data_o, bus.cache_byte_o, bus.cache_status_o};
        total++;
        if ({a.lg, a.sg} !== {e.lg, e.sg}) begin
          bad++;
          $display("FAIL grant t=%0t: got ldu=%b stu=%b want ldu=%b stu=%b",
                   $time, a.lg, a.sg, e.lg, e.sg);
        end
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL bus t=%0t: got %h want %h", $time, a, e);
        end
        total++;
        if (a.lg === 1'b1 && a.sg === 1'b1) begin
          bad++;
          $display("FAIL mutex t=%0t: got both grants want at most one", $time);
        end
      end
    end
  end

  initial begin : stim
    rst_n_i = 1'b0; halt_i = 1'b0;
    bus.ldu_request_i = 1'b0; bus.ldu_release_i = 1'b0;
    bus.stu_request_i = 1'b0; bus.stu_release_i = 1'b0;

    // lreq lrel sreq srel halt rst
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, (i == 1), 1, 1);
    step(0, 0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
    end

    step(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk_i);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single data-cache array port (data, tag, status read/write enables) between the load controller and the store controller.
- Grants are transaction-locked: a requester keeps the port from its first cache read until it signals release. This covers the store read-outcome-writethrough sequence.
- Sits between the two cache controllers and the cache arrays. The grant output becomes the controllers' permission to issue cache commands.

Parameters:
- STARVE_LIMIT, 8: cycles a pending store may wait before forced grant (used only with the optional feature); legal 1..255.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- halt_i  in  1  freeze arbiter state and pointer
- ldu_request_i  in  1  load controller wants port
- ldu_release_i  in  1  load controller finished, port released
- ldu_grant_o  out  1  load controller owns port
- ldu_address_i  in  32  load cache address
- ldu_read_i  in  data_enable_t  load cache read enables
- ldu_write_i  in  data_enable_t  load (refill) write enables
- ldu_data_i  in  32  load refill data
- ldu_status_i  in  status_packet_t  load status write value
- stu_request_i  in  1  store controller wants port
- stu_release_i  in  1  store controller finished
- stu_grant_o  out  1  store controller owns port
- stu_address_i  in  32  store cache address
- stu_read_i  in  data_enable_t  store read enables
- stu_write_i  in  data_enable_t  store write enables
- stu_data_i  in  32  store data
- stu_byte_i  in  4  store byte enables
- stu_status_i  in  status_packet_t  store status write value
- cache_address_o  out  32  muxed address
- cache_read_o  out  data_enable_t  muxed read enables
- cache_write_o  out  data_enable_t  muxed write enables
- cache_data_o  out  32  muxed write data
- cache_byte_o  out  4  muxed byte enables; '1 when load owns
- cache_status_o  out  status_packet_t  muxed status value

Behaviour:
- State register (async reset, updates only when !halt_i): IDLE, LOAD_OWN, STORE_OWN.
- Round-robin pointer last_o: reset = STORE, so the load wins the first tie.
- Reset values:
  - state IDLE, both grants 0.
  - all cache_* outputs 0, except cache_address_o, which follows the selected requester (selection = load when neither is granted).
- IDLE arbitration, combinational, zero latency: the winner's grant goes high in the same cycle as its request and its cache commands pass through that cycle. Next state is the winner's OWN state; the pointer updates to the winner.
  - One requester: it wins.
  - Both requesting: the one not equal to last_o wins.
- OWN states:
  - Grant is held, including across cycles where the owner drops request.
  - Owner release_i = 1:
    - If the other requester is pending: hand off next cycle directly to the other's OWN state; no IDLE bubble. The released owner keeps its grant during the release cycle.
    - Otherwise: return to IDLE next cycle.
- Ignored inputs:
  - release_i from a non-owner, or asserted in IDLE.
  - request_i together with release_i from the same owner; re-arbitration happens next cycle.
- Mux: cache_* = the granted requester's inputs; with no grant, all enables are 0.
- Mutual exclusion: ldu_grant_o and stu_grant_o are never both 1.
- halt_i = 1:
  - State and pointer frozen; grants keep their current values.
  - In IDLE, the combinational grant is suppressed.
- Reset mid-transaction: immediate return to IDLE with grants 0. The controllers are reset by the same signal.

Optional Feature:
- Macro DCACHE_ARB_STARVE_GUARD_EN.
- Defined:
  - Arbitration becomes fixed load priority.
  - 8-bit counter starve_cnt increments each unhalted cycle where stu_request_i = 1 and stu_grant_o = 0; it saturates at STARVE_LIMIT and clears on store grant.
  - When starve_cnt == STARVE_LIMIT, the store wins the next arbitration or handoff over a pending load.
- Undefined: pure round-robin, no counter, STARVE_LIMIT unused.

Decomposition:
- cache_pkg: data_enable_t and status_packet_t (already present); add arb_state_t {IDLE, LOAD_OWN, STORE_OWN} and arb_owner_t {LOAD, STORE}.
- No sub-module. The mux is a small always_comb; the starvation counter stays inline under the macro.

Test Plan:
- Reset, then ldu_request_i = 1 with address 0x100 -> ldu_grant_o = 1 the same cycle, cache_address_o = 0x100, state LOAD_OWN next cycle.
- Both request in IDLE right after reset -> load granted. After ldu_release_i, stu_grant_o = 1 the next cycle with no idle cycle. A following tie goes to the load again.
- Store owns port and drops stu_request_i for 3 cycles while ldu_request_i = 1 -> stu_grant_o stays 1, ldu_grant_o stays 0 until stu_release_i.
- halt_i = 1 for 4 cycles during STORE_OWN with stu_release_i pulsed -> no state change; release takes effect only after halt deasserts.
- rst_n_i asserted mid-LOAD_OWN, asynchronously -> grants and enables 0 before the next clock edge.
- With DCACHE_ARB_STARVE_GUARD_EN and STARVE_LIMIT = 3: continuous load requests and a pending store -> store granted at the first arbitration after counter = 3; counter reads 0 after the grant.
